// File: rtl/dsp_pack_pkg.sv
// dsp_pack_pkg: shared constants and helpers for the packed dual-weight DSP path.
//   P_W        - width of the DSP P word
//   LOW_W_DFLT - default bit position of the high field in P
//   unpack_lo  - sign-extended low field of P
//   unpack_hi  - high field of P with the borrow caused by a negative low field undone
//   add_wrap   - two's-complement add wrapped to w bits, with a signed-overflow flag
// All helpers work in X_W-bit signed arithmetic; callers slice the result down.
package dsp_pack_pkg;

  localparam int P_W        = 48;
  localparam int LOW_W_DFLT = 18;
  localparam int X_W        = 64;

  typedef logic signed [X_W-1:0] xw_t;

  typedef struct packed {
    logic ovf;
    xw_t  sum;
  } add_t;

  function automatic xw_t unpack_lo(input logic [P_W-1:0] p, input int low_w);
    xw_t x;
    x = {{(X_W-P_W){1'b0}}, p};
    x = x <<< (X_W - low_w);
    return x >>> (X_W - low_w);
  endfunction

  // The packer adds a signed low product into the word, so a negative low field
  // borrows one from the high field; adding the low sign bit back restores it.
  function automatic xw_t unpack_hi(input logic [P_W-1:0] p, input int low_w);
    xw_t x;
    xw_t lo;
    lo = unpack_lo(p, low_w);
    x  = {{(X_W-P_W){p[P_W-1]}}, p};
    x  = x >>> low_w;
    return x + {{(X_W-1){1'b0}}, lo[X_W-1]};
  endfunction

  // Operands must already be sign-extended w-bit values (w < X_W), so the
  // X_W-bit sum is exact and overflow is simply "wrapping changed the value".
  function automatic add_t add_wrap(input xw_t a, input xw_t b, input int w);
    add_t r;
    xw_t  s;
    s     = a + b;
    r.sum = (s <<< (X_W - w)) >>> (X_W - w);
    r.ovf = (r.sum != s);
    return r;
  endfunction

endpackage

// File: rtl/dsp_field_acc.sv
// dsp_field_acc: one signed field accumulator with group restart and sticky overflow.
//   clk, rst  - clock, synchronous active-high reset
//   upd       - a stage-1 beat is consumed this cycle
//   first     - beat restarts the group (acc loads the field, overflow clears)
//   field     - signed field of the beat
//   acc_nxt   - value the accumulator takes on this beat (used for the result capture)
//   ovf_nxt   - sticky overflow including this beat
module dsp_field_acc
  import dsp_pack_pkg::*;
#(
  parameter int ACC_W = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    upd,
  input  logic                    first,
  input  logic signed [ACC_W-1:0] field,
  output logic signed [ACC_W-1:0] acc_nxt,
  output logic                    ovf_nxt
);

  logic signed [ACC_W-1:0] acc;
  logic                    ovf;
  add_t                    r;
  logic                    unused_hi;

  always_comb begin
    r       = add_wrap(X_W'(acc), X_W'(field), ACC_W);
    acc_nxt = first ? field : r.sum[ACC_W-1:0];
    ovf_nxt = first ? 1'b0 : (ovf | r.ovf);
  end

  assign unused_hi = ^r.sum[X_W-1:ACC_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      ovf <= 1'b0;
    end else if (upd) begin
      acc <= acc_nxt;
      ovf <= ovf_nxt;
    end
  end

endmodule

// File: rtl/dsp_unpack_acc.sv
// dsp_unpack_acc: splits packed DSP P words into low/high signed partial sums,
// accumulates both over a group of beats and hands the result downstream.
//   I_clk, I_rst         - clock, synchronous active-high reset
//   I_p, I_p_vld         - packed P word and its valid
//   I_first, I_last      - group delimiters, qualified by I_p_vld
//   O_p_rdy              - a beat is accepted this cycle when I_p_vld is high
//   O_sum_l, O_sum_h     - accumulated low/high sums of the finished group
//   O_ovf                - accumulator overflow seen anywhere in that group
//   O_vld, I_rdy         - result handshake
// Pipeline: stage 1 unpacks, stage 2 accumulates and captures on the last beat,
// so a last beat accepted in cycle t shows O_vld in cycle t+2. The whole pipe
// stalls on a held result (O_vld && !I_rdy). ACC_W below 48-LOW_W wraps the
// high field; ACC_W must stay below 64.
module dsp_unpack_acc
  import dsp_pack_pkg::*;
#(
  parameter int LOW_W = LOW_W_DFLT,
  parameter int ACC_W = 32
) (
  input  logic             I_clk,
  input  logic             I_rst,
  input  logic [P_W-1:0]   I_p,
  input  logic             I_p_vld,
  input  logic             I_first,
  input  logic             I_last,
  output logic             O_p_rdy,
  output logic [ACC_W-1:0] O_sum_l,
  output logic [ACC_W-1:0] O_sum_h,
  output logic             O_ovf,
  output logic             O_vld,
  input  logic             I_rdy
);

  logic                    en;
  logic                    upd;
  xw_t                     lo_x;
  xw_t                     hi_x;
  logic                    unused_x;

  logic                    s1_vld;
  logic                    s1_first;
  logic                    s1_last;
  logic signed [ACC_W-1:0] s1_lo;
  logic signed [ACC_W-1:0] s1_hi;

  logic signed [ACC_W-1:0] nxt_l;
  logic signed [ACC_W-1:0] nxt_h;
  logic                    ovf_l;
  logic                    ovf_h;

  assign en      = !O_vld || I_rdy;
  assign O_p_rdy = en;
  assign upd     = s1_vld && en;

  assign lo_x     = unpack_lo(I_p, LOW_W);
  assign hi_x     = unpack_hi(I_p, LOW_W);
  assign unused_x = ^{lo_x[X_W-1:ACC_W], hi_x[X_W-1:ACC_W]};

  // Stage 1: unpacked fields plus group markers. Fields keep their old value
  // on bubbles; only s1_vld tracks whether they mean anything.
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      s1_vld   <= 1'b0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
      s1_lo    <= '0;
      s1_hi    <= '0;
    end else if (en) begin
      s1_vld <= I_p_vld;
      if (I_p_vld) begin
        s1_first <= I_first;
        s1_last  <= I_last;
        s1_lo    <= lo_x[ACC_W-1:0];
        s1_hi    <= hi_x[ACC_W-1:0];
      end
    end
  end

  // Stage 2: one accumulator per field. Each keeps its own sticky flag; the
  // group flag is their OR, which equals OR-ing both adds every beat.
  dsp_field_acc #(.ACC_W(ACC_W)) u_acc_l (
    .clk     (I_clk),
    .rst     (I_rst),
    .upd     (upd),
    .first   (s1_first),
    .field   (s1_lo),
    .acc_nxt (nxt_l),
    .ovf_nxt (ovf_l)
  );

  dsp_field_acc #(.ACC_W(ACC_W)) u_acc_h (
    .clk     (I_clk),
    .rst     (I_rst),
    .upd     (upd),
    .first   (s1_first),
    .field   (s1_hi),
    .acc_nxt (nxt_h),
    .ovf_nxt (ovf_h)
  );

  // Result register. A new result may land in the same cycle the old one is
  // taken (upd implies en), so capture has priority over the valid clear.
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      O_vld   <= 1'b0;
      O_sum_l <= '0;
      O_sum_h <= '0;
      O_ovf   <= 1'b0;
    end else if (upd && s1_last) begin
      O_vld   <= 1'b1;
      O_sum_l <= nxt_l;
      O_sum_h <= nxt_h;
      O_ovf   <= ovf_l | ovf_h;
    end else if (I_rdy) begin
      O_vld <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dsp_unpack_acc.sv
// tb_dsp_unpack_acc: drives a 32-bit and a 20-bit accumulator instance with the
// same beats. Expected sums come from the weight*feature products that built
// each P word, accumulated in wide integers and wrapped per instance width.
module tb_dsp_unpack_acc;

  localparam int LW  = 18;
  localparam int AW  = 32;
  localparam int AWS = 20;

  logic           I_clk = 1'b0;
  logic           I_rst;
  logic [47:0]    I_p;
  logic           I_p_vld, I_first, I_last, I_rdy;
  logic           O_p_rdy, O_ovf, O_vld;
  logic [AW-1:0]  O_sum_l, O_sum_h;
  logic           s_p_rdy, s_ovf, s_vld;
  logic [AWS-1:0] s_sum_l, s_sum_h;

  always #5 I_clk = ~I_clk;

  dsp_unpack_acc #(.LOW_W(LW), .ACC_W(AW)) dut (
    .I_clk(I_clk), .I_rst(I_rst), .I_p(I_p), .I_p_vld(I_p_vld),
    .I_first(I_first), .I_last(I_last), .O_p_rdy(O_p_rdy),
    .O_sum_l(O_sum_l), .O_sum_h(O_sum_h), .O_ovf(O_ovf), .O_vld(O_vld),
    .I_rdy(I_rdy)
  );

  dsp_unpack_acc #(.LOW_W(LW), .ACC_W(AWS)) dut_s (
    .I_clk(I_clk), .I_rst(I_rst), .I_p(I_p), .I_p_vld(I_p_vld),
    .I_first(I_first), .I_last(I_last), .O_p_rdy(s_p_rdy),
    .O_sum_l(s_sum_l), .O_sum_h(s_sum_h), .O_ovf(s_ovf), .O_vld(s_vld),
    .I_rdy(I_rdy)
  );

  typedef struct {
    longint l, h, ls, hs;
    bit     ovf, ovfs;
  } exp_t;

  exp_t   sb[$];
  int     n_chk  = 0;
  int     n_pass = 0;
  longint m_l, m_h, m_ls, m_hs;
  bit     m_ovf, m_ovfs;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
  endtask

  function automatic longint wrap(input longint v, input int w);
    return (v <<< (64 - w)) >>> (64 - w);
  endfunction

  task automatic acc_step(inout longint a, inout bit o, input longint f, input int w,
                          input bit first);
    longint fw, t;
    fw = wrap(f, w);
    if (first) begin
      a = fw;
      o = 1'b0;
    end else begin
      t = a + fw;
      if (wrap(t, w) != t) o = 1'b1;
      a = wrap(t, w);
    end
  endtask

  task automatic model_beat(input longint lo, input longint hi, input bit first, input bit last);
    bit o_tmp;
    o_tmp = m_ovf;
    acc_step(m_l, o_tmp, lo, AW, first);
    acc_step(m_h, o_tmp, hi, AW, 1'b0 | (first ? 1'b0 : 1'b0));
    // high add must not reset the flag the low add just set; redo cleanly
    o_tmp = first ? 1'b0 : m_ovf;
    begin
      bit ol, oh;
      longint al, ah;
      al = m_l; ah = m_h;
      ol = o_tmp; oh = o_tmp;
      al = 0; ah = 0;
    end
    m_ovf = o_tmp;
  endtask

  // Model state per instance: each field keeps its own wrapped sum, and the
  // group flag is the OR of both fields' sticky flags.
  longint q_l, q_h, q_ls, q_hs;
  bit     f_l, f_h, f_ls, f_hs;

  task automatic model(input longint lo, input longint hi, input bit first, input bit last);
    exp_t e;
    acc_step(q_l,  f_l,  lo, AW,  first);
    acc_step(q_h,  f_h,  hi, AW,  first);
    acc_step(q_ls, f_ls, lo, AWS, first);
    acc_step(q_hs, f_hs, hi, AWS, first);
    if (last) begin
      e.l = q_l; e.h = q_h; e.ls = q_ls; e.hs = q_hs;
      e.ovf = f_l | f_h; e.ovfs = f_ls | f_hs;
      sb.push_back(e);
    end
  endtask

  // Call just after a rising edge. Holds the beat until O_p_rdy, returns just
  // after the accepting edge with the beat still driven (no bubble).
  task automatic send(input logic [47:0] p, input longint lo, input longint hi,
                      input bit first, input bit last);
    int n = 0;
    I_p = p; I_p_vld = 1'b1; I_first = first; I_last = last;
    @(negedge I_clk);
    while (!O_p_rdy && n < 200) begin
      @(negedge I_clk);
      n++;
    end
    if (!O_p_rdy) chk("send_timeout", 0, 1);
    else begin
      @(posedge I_clk); #1;
      model(lo, hi, first, last);
    end
  endtask

  task automatic beat(input int wh, input int wl, input int f, input bit first, input bit last);
    longint lo, hi;
    lo = longint'(f) * wl;
    hi = longint'(f) * wh;
    send(48'((hi <<< LW) + lo), lo, hi, first, last);
  endtask

  // Bubbles with first/last driven high to show they are ignored without valid.
  task automatic idle(input int n);
    I_p_vld = 1'b0; I_first = 1'b1; I_last = 1'b1; I_p = 48'hFFFF_FFFF_FFFF;
    repeat (n) begin @(posedge I_clk); #1; end
    I_first = 1'b0; I_last = 1'b0;
  endtask

  task automatic rand_group(input int len);
    for (int i = 0; i < len; i++)
      beat(int'($urandom_range(0, 200)) - 100, int'($urandom_range(0, 200)) - 100,
           int'($urandom_range(0, 255)) - 128, i == 0, i == len - 1);
  endtask

  task automatic do_reset();
    I_rst = 1'b1; I_p_vld = 1'b0; I_first = 1'b0; I_last = 1'b0;
    @(posedge I_clk); #1;
    I_rst = 1'b0;
    sb.delete();
    q_l = 0; q_h = 0; q_ls = 0; q_hs = 0;
    f_l = 0; f_h = 0; f_ls = 0; f_hs = 0;
  endtask

  task automatic check_reset(input string tag);
    @(negedge I_clk);
    chk({tag, "_vld"},   O_vld, 0);
    chk({tag, "_sum_l"}, O_sum_l, 0);
    chk({tag, "_sum_h"}, O_sum_h, 0);
    chk({tag, "_ovf"},   O_ovf, 0);
    chk({tag, "_p_rdy"}, O_p_rdy, 1);
    chk({tag, "_s_vld"}, s_vld, 0);
    chk({tag, "_s_sum"}, {s_sum_l, s_sum_h}, 0);
    chk({tag, "_s_rdy"}, s_p_rdy, 1);
    @(posedge I_clk); #1;
  endtask

  task automatic drain();
    int n = 0;
    I_p_vld = 1'b0; I_first = 1'b0; I_last = 1'b0;
    while ((sb.size() != 0 || O_vld) && n < 100) begin
      @(posedge I_clk); #1;
      n++;
    end
    chk("drain_left", sb.size(), 0);
  endtask

  // Output monitor: compare on every handshake, and check a held result stays put.
  logic [AW-1:0]  pl, ph;
  logic [AWS-1:0] psl, psh;
  logic           po, pso;
  bit             held = 1'b0;

  always @(negedge I_clk) begin
    exp_t e;
    if (I_rst) held = 1'b0;
    else begin
      if (held) begin
        chk("hold_sum_l", O_sum_l, pl);
        chk("hold_sum_h", O_sum_h, ph);
        chk("hold_s_sum", {s_sum_l, s_sum_h, s_ovf, O_ovf}, {psl, psh, pso, po});
      end
      if (O_vld || s_vld) chk("vld_match", s_vld, O_vld);
      if (O_vld && !I_rdy) chk("p_rdy_stall", O_p_rdy, 0);
      if (O_vld && I_rdy) begin
        if (sb.size() == 0) chk("unexpected_out", 1, 0);
        else begin
          e = sb.pop_front();
          chk("sum_l",   $signed(O_sum_l), e.l);
          chk("sum_h",   $signed(O_sum_h), e.h);
          chk("ovf",     O_ovf, e.ovf);
          chk("s_sum_l", $signed(s_sum_l), e.ls);
          chk("s_sum_h", $signed(s_sum_h), e.hs);
          chk("s_ovf",   s_ovf, e.ovfs);
        end
      end
      held = O_vld && !I_rdy;
      pl = O_sum_l; ph = O_sum_h; po = O_ovf;
      psl = s_sum_l; psh = s_sum_h; pso = s_ovf;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    I_rst = 1'b0; I_p = '0; I_p_vld = 1'b0; I_first = 1'b0; I_last = 1'b0; I_rdy = 1'b1;
    @(posedge I_clk); #1;
    do_reset();
    check_reset("rst");

    // Single-beat group (w_h=3, w_l=-2, f=5): result two cycles after acceptance.
    beat(3, -2, 5, 1, 1);
    I_p_vld = 1'b0; I_first = 1'b0; I_last = 1'b0;
    @(negedge I_clk);
    chk("lat_t1_vld", O_vld, 0);
    @(posedge I_clk); #1;
    @(negedge I_clk);
    chk("lat_t2_vld", O_vld, 1);
    chk("lat_sum_l", $signed(O_sum_l), -10);
    chk("lat_sum_h", $signed(O_sum_h), 15);
    @(posedge I_clk); #1;

    // Four-beat group streamed back-to-back: low 16426, high -16258.
    beat(1, 1, 1, 1, 0);
    beat(-1, 2, 3, 0, 0);
    beat(127, -128, -128, 0, 0);
    beat(0, 5, 7, 0, 1);
    idle(3);

    // Back-to-back groups, last then first on consecutive beats.
    for (int g = 0; g < 6; g++) rand_group(int'($urandom_range(1, 4)));
    drain();

    // Result held with two more beats offered; release later.
    I_rdy = 1'b0;
    beat(2, -3, 9, 1, 0);
    beat(-5, 4, -6, 0, 1);
    fork
      begin
        beat(7, 7, 7, 1, 0);
        beat(-9, -1, 11, 0, 1);
        I_p_vld = 1'b0;
      end
      begin
        repeat (8) begin @(posedge I_clk); #1; end
        I_rdy = 1'b1;
      end
    join
    drain();

    // Non-first beat after a completed group piles onto the stale sum.
    beat(4, 4, 4, 1, 1);
    beat(1, -1, 3, 0, 1);
    // First while a group is open restarts it.
    beat(50, 50, 50, 1, 0);
    beat(60, 60, 60, 0, 0);
    beat(-2, 3, 10, 1, 0);
    beat(1, 1, 1, 0, 1);
    drain();

    // Low field +131071 x8 overflows 20 bits, not 32; next group clean.
    for (int i = 0; i < 8; i++) send(48'd131071, 131071, 0, i == 0, i == 7);
    beat(1, 1, 1, 1, 1);
    // High field 2^28 x8 overflows 32 bits; wraps to 0 in the 20-bit instance.
    for (int i = 0; i < 8; i++) send(48'(longint'(1) <<< 46), 0, longint'(1) <<< 28, i == 0, i == 7);
    beat(-1, -1, 1, 1, 1);
    drain();

    // Random downstream backpressure.
    fork
      begin
        for (int g = 0; g < 5; g++) rand_group(int'($urandom_range(1, 4)));
        I_p_vld = 1'b0;
      end
      begin
        repeat (60) begin @(posedge I_clk); #1; I_rdy = 1'($urandom_range(0, 1)); end
        I_rdy = 1'b1;
      end
    join
    drain();

    // Reset mid-group, then a beat without first accumulates onto zero.
    beat(9, 9, 9, 1, 0);
    beat(8, 8, 8, 0, 0);
    do_reset();
    check_reset("rst_mid");
    beat(3, -7, 5, 0, 1);
    beat(2, 2, 2, 1, 1);
    drain();

    // Reset with a held result.
    I_rdy = 1'b0;
    beat(6, -6, 6, 1, 1);
    I_p_vld = 1'b0;
    repeat (3) begin @(posedge I_clk); #1; end
    @(negedge I_clk);
    chk("held_vld", O_vld, 1);
    @(posedge I_clk); #1;
    do_reset();
    check_reset("rst_held");
    I_rdy = 1'b1;
    beat(-3, 1, 12, 1, 0);
    beat(5, -2, 4, 0, 1);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
